// File: rtl/demux32_regbank.sv
// demux32_regbank: 1-to-32 write demultiplexer into a registered bank of N-bit
// entries with per-entry valid bits and a 32-cycle sequential clear sweep.
// Optional build macro: DEMUX32_ZERO_REG0_EN (entry 0 hardwired to zero).
module demux32_regbank #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  logic [4:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    output logic         wr_ready,
    input  logic         clr_req,
    output logic         busy,
    output logic [31:0]  valid,
    output logic [N-1:0] out00,
    output logic [N-1:0] out01,
    output logic [N-1:0] out02,
    output logic [N-1:0] out03,
    output logic [N-1:0] out04,
    output logic [N-1:0] out05,
    output logic [N-1:0] out06,
    output logic [N-1:0] out07,
    output logic [N-1:0] out08,
    output logic [N-1:0] out09,
    output logic [N-1:0] out10,
    output logic [N-1:0] out11,
    output logic [N-1:0] out12,
    output logic [N-1:0] out13,
    output logic [N-1:0] out14,
    output logic [N-1:0] out15,
    output logic [N-1:0] out16,
    output logic [N-1:0] out17,
    output logic [N-1:0] out18,
    output logic [N-1:0] out19,
    output logic [N-1:0] out20,
    output logic [N-1:0] out21,
    output logic [N-1:0] out22,
    output logic [N-1:0] out23,
    output logic [N-1:0] out24,
    output logic [N-1:0] out25,
    output logic [N-1:0] out26,
    output logic [N-1:0] out27,
    output logic [N-1:0] out28,
    output logic [N-1:0] out29,
    output logic [N-1:0] out30,
    output logic [N-1:0] out31
);

    typedef enum logic {StIdle, StClear} state_e;

    state_e        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [N-1:0]  entry_q [32];
    logic [31:0]   valid_q;
    logic [31:0]   wr_en;
    logic [31:0]   clr_en;

    // Writes are only taken in IDLE and never while reset is asserted.
    assign wr_ready = (state_q == StIdle) && rst;
    assign busy     = (state_q == StClear);
    assign valid    = valid_q;

    // One-hot write and sweep-clear enables; they never overlap since writes need IDLE.
    always_comb begin
        wr_en  = '0;
        clr_en = '0;
        if (wr_ena && wr_ready) begin
            wr_en = 32'd1 << wr_addr;
        end
`ifdef DEMUX32_ZERO_REG0_EN
        // Entry 0 is hardwired: the write is accepted but discarded.
        wr_en[0] = 1'b0;
`endif
        if (state_q == StClear) begin
            clr_en = 32'd1 << cnt_q;
        end
    end

    // Next-state logic for the IDLE/CLEAR controller and sweep counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    cnt_d   = 5'd0;
                end
            end
            StClear: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Entry bank and valid bits: write-enabled entry loads, swept entry zeroes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 32; k++) begin
                entry_q[k] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int k = 0; k < 32; k++) begin
                if (wr_en[k]) begin
                    entry_q[k] <= wr_data;
                end else if (clr_en[k]) begin
                    entry_q[k] <= '0;
                end
            end
            valid_q <= (valid_q | wr_en) & ~clr_en;
        end
    end

    assign out00 = entry_q[0];
    assign out01 = entry_q[1];
    assign out02 = entry_q[2];
    assign out03 = entry_q[3];
    assign out04 = entry_q[4];
    assign out05 = entry_q[5];
    assign out06 = entry_q[6];
    assign out07 = entry_q[7];
    assign out08 = entry_q[8];
    assign out09 = entry_q[9];
    assign out10 = entry_q[10];
    assign out11 = entry_q[11];
    assign out12 = entry_q[12];
    assign out13 = entry_q[13];
    assign out14 = entry_q[14];
    assign out15 = entry_q[15];
    assign out16 = entry_q[16];
    assign out17 = entry_q[17];
    assign out18 = entry_q[18];
    assign out19 = entry_q[19];
    assign out20 = entry_q[20];
    assign out21 = entry_q[21];
    assign out22 = entry_q[22];
    assign out23 = entry_q[23];
    assign out24 = entry_q[24];
    assign out25 = entry_q[25];
    assign out26 = entry_q[26];
    assign out27 = entry_q[27];
    assign out28 = entry_q[28];
    assign out29 = entry_q[29];
    assign out30 = entry_q[30];
    assign out31 = entry_q[31];

endmodule
